usart_tx_fsm: RTL

USART transmitter control block: accepts a data word from the CPU-side data register write strobe, holds it in a one-entry transmit buffer, and serialises it onto `o_txd` as start bit, 5–9 data bits LSB first, optional parity and 1 or 2 stop bits. It is the transmit-side counterpart of the receiver FSM. It sits between the register file (UDR/UCSR fields) and the TXD pin driver, paced by a bit-rate enable from the clock generator.

---
 rtl/usart_tx_fsm_if.sv | 29 ++
 rtl/usart_tx_fsm.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/usart_tx_fsm_if.sv
// Transmit-side register/pin bundle for usart_tx_fsm: control fields and write strobe in,
// serial line, status flags and FSM state out.
interface usart_tx_fsm_if;
  logic       i_TXEN;
  logic       i_txclk;
  logic [2:0] i_ucsz;
  logic [1:0] i_upm;
  logic       i_usbs;
  logic [8:0] i_udr;
  logic       i_udr_wr;
  logic       i_txc_clr;
  logic       o_txd;
  logic       o_udre;
  logic       o_txc;
  logic       o_busy;
  logic [2:0] o_state;

  // Handshake: a write is taken on a cycle with i_udr_wr=1 and o_udre=1; o_udre is the
  // ready, i_udr_wr the single-cycle valid, and a write with o_udre=0 is dropped.
  modport master (
    output i_TXEN, i_txclk, i_ucsz, i_upm, i_usbs, i_udr, i_udr_wr, i_txc_clr,
    input  o_txd, o_udre, o_txc, o_busy, o_state
  );

  modport slave (
    input  i_TXEN, i_txclk, i_ucsz, i_upm, i_usbs, i_udr, i_udr_wr, i_txc_clr,
    output o_txd, o_udre, o_txc, o_busy, o_state
  );
endinterface

// File: rtl/usart_tx_fsm.sv
// USART transmitter: one-entry transmit buffer feeding a frame serialiser
// (start, 5-9 data bits LSB first, optional parity, 1 or 2 stop bits).
module usart_tx_fsm (
  input  logic          i_fosk,
  input  logic          i_rst_n,
  usart_tx_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_e;

  state_e     state_q;
  logic       txd_q;
  logic       udre_q;
  logic       txc_q;
  logic       par_q;
  logic       par_en_q;
  logic       par_odd_q;
  logic       usbs_q;
  logic [8:0] buf_q;
  logic [8:0] shift_q;
  logic [3:0] cnt_q;
  logic [3:0] nbits_q;
  logic [3:0] nbits_d;
  logic       frame_end;
  logic       load;

  always_comb begin
    nbits_d = 4'd8;
    case (bus.i_ucsz)
      3'b000:  nbits_d = 4'd5;
      3'b001:  nbits_d = 4'd6;
      3'b010:  nbits_d = 4'd7;
      3'b111:  nbits_d = 4'd9;
      default: nbits_d = 4'd8;
    endcase
  end

  // The last stop bit is on the line; the next txclk either ends the frame or starts the next one.
  assign frame_end = (state_q == STOP2) || ((state_q == STOP1) && !usbs_q);
  assign load      = bus.i_txclk && !udre_q && bus.i_TXEN &&
                     ((state_q == IDLE) || frame_end);

  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      udre_q    <= 1'b1;
      txc_q     <= 1'b0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      usbs_q    <= 1'b0;
      buf_q     <= 9'd0;
      shift_q   <= 9'd0;
      cnt_q     <= 4'd0;
      nbits_q   <= 4'd0;
    end else begin
      if (bus.i_udr_wr && udre_q) begin
        buf_q  <= bus.i_udr;
        udre_q <= 1'b0;
      end

      if (bus.i_txc_clr) begin
        txc_q <= 1'b0;
      end

      if (load) begin
        shift_q   <= buf_q;
        udre_q    <= 1'b1;
        par_q     <= 1'b0;
        cnt_q     <= 4'd0;
        txd_q     <= 1'b0;
        state_q   <= START;
        nbits_q   <= nbits_d;
        par_en_q  <= bus.i_upm[1];
        par_odd_q <= bus.i_upm[0];
        usbs_q    <= bus.i_usbs;
      end else if (bus.i_txclk) begin
        case (state_q)
          IDLE: begin
            txd_q <= 1'b1;
          end
          START: begin
            txd_q   <= shift_q[0];
            shift_q <= {1'b0, shift_q[8:1]};
            par_q   <= par_q ^ shift_q[0];
            cnt_q   <= 4'd1;
            state_q <= DATA;
          end
          DATA: begin
            if (cnt_q < nbits_q) begin
              txd_q   <= shift_q[0];
              shift_q <= {1'b0, shift_q[8:1]};
              par_q   <= par_q ^ shift_q[0];
              cnt_q   <= cnt_q + 4'd1;
            end else if (par_en_q) begin
              txd_q   <= par_q ^ par_odd_q;
              state_q <= PARITY;
            end else begin
              txd_q   <= 1'b1;
              state_q <= STOP1;
            end
          end
          PARITY: begin
            txd_q   <= 1'b1;
            state_q <= STOP1;
          end
          STOP1, STOP2: begin
            if ((state_q == STOP1) && usbs_q) begin
              txd_q   <= 1'b1;
              state_q <= STOP2;
            end else begin
              // Frame ends with nothing to load; set wins over a same-cycle clear.
              txd_q   <= 1'b1;
              state_q <= IDLE;
              txc_q   <= 1'b1;
            end
          end
          default: begin
            txd_q   <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_txd   = txd_q;
  assign bus.o_udre  = udre_q;
  assign bus.o_txc   = txc_q;
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_state = state_q;

endmodule
